rdm_harq_combiner: RTL and testbench

- Consumer-side counterpart of the rate-dematching data source. It requests one code block from the source and accepts 96-bit chunks of sixteen 6-bit LLRs over the Request/Valid handshake.
- Each received LLR is soft-combined with the stored 8-bit HARQ LLR using a read-modify-write to HARQ RAM.
- The block sits between the RDM source FSM and the HARQ buffer memory, ahead of the LDPC decoder input.

---
 rtl/rdm_harq_combiner.sv | 179 +++++++++++++++++
 tb/tb_rdm_harq_combiner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdm_harq_combiner.sv
// HARQ soft combiner: pulls one code block of 6-bit LLR chunks from the rate-dematching
// source and read-modify-writes the saturated 8-bit sums into HARQ RAM.

module rdm_harq_lane #(
    parameter int LLR_IN_W  = 6,
    parameter int LLR_ACC_W = 8
) (
    input  logic [LLR_IN_W-1:0]  llr,
    input  logic [LLR_ACC_W-1:0] rd,
    input  logic                 first_tx,
    output logic [LLR_ACC_W-1:0] wr
);
    localparam int SUM_W = LLR_ACC_W + 1;

    logic signed [SUM_W-1:0] llr_x;
    logic signed [SUM_W-1:0] rd_x;
    logic signed [SUM_W-1:0] sum;

    assign llr_x = SUM_W'($signed(llr));
    assign rd_x  = first_tx ? '0 : SUM_W'($signed(rd));
    assign sum   = llr_x + rd_x;

    // One guard bit is enough: overflow shows up as a mismatch of the top two bits.
    always_comb begin
        wr = sum[LLR_ACC_W-1:0];
        if (sum[SUM_W-1] != sum[SUM_W-2])
            wr = sum[SUM_W-1] ? {1'b1, {(LLR_ACC_W-1){1'b0}}} : {1'b0, {(LLR_ACC_W-1){1'b1}}};
    end
endmodule

module rdm_harq_combiner #(
    parameter int LANES     = 16,
    parameter int LLR_IN_W  = 6,
    parameter int LLR_ACC_W = 8,
    parameter int ADDR_W    = 12
) (
    input  logic                        i_core_clk,
    input  logic                        i_rx_rst,
    input  logic                        i_Combine_start,
    input  logic [15:0]                 i_Current_Combine_Ncb_Size,
    input  logic [ADDR_W-1:0]           i_Harq_Base_Addr,
    input  logic                        i_Harq_First_Tx,
    output logic                        o_Combine_process_request,
    output logic                        o_RDM_Data_Request,
    input  logic                        i_RDM_Data_Valid,
    input  logic [LANES*LLR_IN_W-1:0]   i_RDM_Data_Content,
    output logic                        o_Harq_Rd_En,
    output logic [ADDR_W-1:0]           o_Harq_Rd_Addr,
    input  logic [LANES*LLR_ACC_W-1:0]  i_Harq_Rd_Data,
    output logic                        o_Harq_Wr_En,
    output logic [ADDR_W-1:0]           o_Harq_Wr_Addr,
    output logic [LANES*LLR_ACC_W-1:0]  o_Harq_Wr_Data,
    output logic [LANES-1:0]            o_Harq_Wr_Be,
    output logic                        o_Busy,
    output logic                        o_Combine_Done,
    output logic                        o_Extra_Beat_Err
);
    localparam int LANE_BITS = $clog2(LANES);
    localparam int CNT_W     = 16 - LANE_BITS;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_FLUSH, S_DONE} state_t;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    ncb_hi;
    logic [LANE_BITS-1:0]                last_lo;
    logic [ADDR_W-1:0]                   base;
    logic                                first_tx;
    logic [CNT_W-1:0]                    k;

    logic                                wr_vld;
    logic                                wr_last;
    logic [ADDR_W-1:0]                   wr_addr;
    logic [LANES-1:0][LLR_IN_W-1:0]      llr_q;
    logic [LANES-1:0][LLR_ACC_W-1:0]     lane_wr;
    logic [LANES-1:0]                    last_mask;

    logic start_acc;
    logic accept;
    logic is_last;
    logic [ADDR_W-1:0] cur_addr;

    assign start_acc = (state == S_IDLE) && i_Combine_start;
    assign accept    = (state == S_RECV) && i_RDM_Data_Valid;
    assign is_last   = (k == ncb_hi);
    assign cur_addr  = base + ADDR_W'(k);

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt                 = state;
        o_Combine_process_request = 1'b0;
        o_RDM_Data_Request        = 1'b0;
        o_Combine_Done            = 1'b0;
        o_Busy                    = (state != S_IDLE);
        case (state)
            S_IDLE:  if (i_Combine_start) state_nxt = S_REQ;
            S_REQ: begin
                o_Combine_process_request = 1'b1;
                state_nxt                 = S_RECV;
            end
            S_RECV: begin
                o_RDM_Data_Request = 1'b1;
                if (accept && is_last) state_nxt = S_FLUSH;
            end
            S_FLUSH: state_nxt = S_DONE;
            S_DONE: begin
                o_Combine_Done = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            ncb_hi           <= '0;
            last_lo          <= '0;
            base             <= '0;
            first_tx         <= 1'b0;
            k                <= '0;
            o_Extra_Beat_Err <= 1'b0;
        end else begin
            if (start_acc) begin
                ncb_hi   <= i_Current_Combine_Ncb_Size[15:LANE_BITS];
                last_lo  <= i_Current_Combine_Ncb_Size[LANE_BITS-1:0];
                base     <= i_Harq_Base_Addr;
                first_tx <= i_Harq_First_Tx;
                k        <= '0;
            end else if (accept) begin
                k <= k + 1'b1;
            end
            if (start_acc)
                o_Extra_Beat_Err <= 1'b0;
            else if (i_RDM_Data_Valid && (state != S_RECV))
                o_Extra_Beat_Err <= 1'b1;
        end
    end

    // Read is issued with the accepted chunk; its data lands exactly when the write stage needs it.
    assign o_Harq_Rd_En   = accept && !first_tx;
    assign o_Harq_Rd_Addr = o_Harq_Rd_En ? cur_addr : '0;

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            wr_vld  <= 1'b0;
            wr_last <= 1'b0;
            wr_addr <= '0;
            llr_q   <= '0;
        end else begin
            wr_vld <= accept;
            if (accept) begin
                wr_last <= is_last;
                wr_addr <= cur_addr;
                llr_q   <= i_RDM_Data_Content;
            end
        end
    end

    for (genvar m = 0; m < LANES; m++) begin : g_lane
        rdm_harq_lane #(
            .LLR_IN_W  (LLR_IN_W),
            .LLR_ACC_W (LLR_ACC_W)
        ) u_lane (
            .llr      (llr_q[m]),
            .rd       (i_Harq_Rd_Data[m*LLR_ACC_W +: LLR_ACC_W]),
            .first_tx (first_tx),
            .wr       (lane_wr[m])
        );
        assign last_mask[m] = (LANE_BITS'(m) <= last_lo);
    end

    assign o_Harq_Wr_En   = wr_vld;
    assign o_Harq_Wr_Addr = wr_vld ? wr_addr : '0;
    assign o_Harq_Wr_Data = wr_vld ? lane_wr : '0;
    assign o_Harq_Wr_Be   = !wr_vld ? '0 : (wr_last ? last_mask : '1);
endmodule

// File: tb/tb_rdm_harq_combiner.sv
// Directed bench for rdm_harq_combiner: a phase-level model plus a RAM model,
// checked every negedge, with hand-computed literal expectations on key beats.

module tb_rdm_harq_combiner;
    localparam int LANES = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [15:0]  ncb;
    logic [11:0]  base_in;
    logic         first_in;
    logic         req;
    logic         rdm_req;
    logic         valid;
    logic [95:0]  content;
    logic         rd_en;
    logic [11:0]  rd_addr;
    logic [127:0] rd_data;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic         busy;
    logic         done;
    logic         err;

    rdm_harq_combiner dut (
        .i_core_clk                 (clk),
        .i_rx_rst                   (rst),
        .i_Combine_start            (start),
        .i_Current_Combine_Ncb_Size (ncb),
        .i_Harq_Base_Addr           (base_in),
        .i_Harq_First_Tx            (first_in),
        .o_Combine_process_request  (req),
        .o_RDM_Data_Request         (rdm_req),
        .i_RDM_Data_Valid           (valid),
        .i_RDM_Data_Content         (content),
        .o_Harq_Rd_En               (rd_en),
        .o_Harq_Rd_Addr             (rd_addr),
        .i_Harq_Rd_Data             (rd_data),
        .o_Harq_Wr_En               (wr_en),
        .o_Harq_Wr_Addr             (wr_addr),
        .o_Harq_Wr_Data             (wr_data),
        .o_Harq_Wr_Be               (wr_be),
        .o_Busy                     (busy),
        .o_Combine_Done             (done),
        .o_Extra_Beat_Err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HARQ RAM: synchronous read, one cycle latency
    logic [127:0] ram [0:4095];
    initial rd_data = '0;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        if (v > 127)  return 8'h7F;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    function automatic logic [127:0] combine(input logic [95:0] c, input logic [127:0] r, input logic f);
        logic [127:0] o;
        int l, s;
        o = '0;
        for (int m = 0; m < LANES; m++) begin
            l = $signed(c[6*m +: 6]);
            s = f ? 0 : $signed(r[8*m +: 8]);
            o[8*m +: 8] = sat8(l + s);
        end
        return o;
    endfunction

    function automatic logic [127:0] be_mask(input logic [15:0] be);
        logic [127:0] o;
        for (int m = 0; m < LANES; m++) o[8*m +: 8] = be[m] ? 8'hFF : 8'h00;
        return o;
    endfunction

    // Model: phase 0 idle, 1 request, 2 receiving, 3 flushing, 4 done
    int           m_phase = 0;
    int           m_k = 0, m_nch = 0, m_last = 0;
    logic [11:0]  m_base = '0;
    logic         m_first = 1'b0;
    logic         m_err = 1'b0;
    logic         m_wr = 1'b0;
    logic [11:0]  m_wr_addr = '0;
    logic [127:0] m_wr_data = '0;
    logic [15:0]  m_be = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_k = 0; m_wr = 1'b0; m_err = 1'b0;
        end else begin
            m_wr = 1'b0;
            if (valid && m_phase != 2) m_err = 1'b1;
            case (m_phase)
                0: if (start) begin
                    m_nch   = int'(ncb[15:4]) + 1;
                    m_last  = int'(ncb[3:0]) + 1;
                    m_base  = base_in;
                    m_first = first_in;
                    m_k     = 0;
                    m_err   = 1'b0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: if (valid) begin
                    m_wr      = 1'b1;
                    m_wr_addr = 12'(m_base + m_k);
                    m_wr_data = combine(content, ram[m_wr_addr], m_first);
                    m_be      = (m_k == m_nch - 1) ? 16'((32'd1 << m_last) - 1) : 16'hFFFF;
                    m_k++;
                    if (m_k == m_nch) m_phase = 3;
                end
                3: m_phase = 4;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [127:0] mk;
        chk("busy", 128'(busy), 128'(m_phase != 0));
        chk("proc_req", 128'(req), 128'(m_phase == 1));
        chk("data_req", 128'(rdm_req), 128'(m_phase == 2));
        chk("done", 128'(done), 128'(m_phase == 4));
        chk("extra_err", 128'(err), 128'(m_err));
        chk("wr_en", 128'(wr_en), 128'(m_wr));
        chk("rd_en", 128'(rd_en), 128'(m_phase == 2 && valid && !m_first));
        if (m_wr && wr_en) begin
            mk = be_mask(m_be);
            chk("wr_addr", 128'(wr_addr), 128'(m_wr_addr));
            chk("wr_be", 128'(wr_be), 128'(m_be));
            chk("wr_data", wr_data & mk, m_wr_data & mk);
        end
        if (m_phase == 2 && valid && !m_first && rd_en)
            chk("rd_addr", 128'(rd_addr), 128'(12'(m_base + m_k)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [11:0] b, input logic f);
        start = 1'b1; ncb = n; base_in = b; first_in = f;
        tick();
        start = 1'b0;
        chk("lit_req_after_start", 128'(req), 128'(1));
        tick();
    endtask

    task automatic send(input logic [95:0] c);
        valid = 1'b1; content = c;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ncb = '0; base_in = '0; first_in = 1'b0;
        valid = 1'b0; content = '0;
        for (int a = 0; a < 4096; a++) ram[a] = '0;
        tick(); tick();
        chk("lit_reset_busy", 128'(busy), 128'(0));
        chk("lit_reset_wr_en", 128'(wr_en), 128'(0));
        rst = 1'b0;
        tick();

        // first transmission, 2 full chunks of +5
        do_start(16'd31, 12'h010, 1'b1);
        send({16{6'd5}});
        chk("lit_t1_addr0", 128'(wr_addr), 128'(12'h010));
        chk("lit_t1_data0", wr_data, {16{8'h05}});
        chk("lit_t1_be0", 128'(wr_be), 128'(16'hFFFF));
        send({16{6'd5}});
        chk("lit_t1_addr1", 128'(wr_addr), 128'(12'h011));
        tick();
        chk("lit_t1_done", 128'(done), 128'(1));
        tick(); tick();

        // combine with stored 0x10, partial last chunk
        ram[12'h100] = {16{8'h10}};
        ram[12'h101] = {16{8'h10}};
        do_start(16'd20, 12'h100, 1'b0);
        send({16{6'd3}});
        chk("lit_t2_data0", wr_data, {16{8'h13}});
        send({16{6'd3}});
        chk("lit_t2_be1", 128'(wr_be), 128'(16'h001F));
        chk("lit_t2_data1", 128'(wr_data[39:0]), 128'({5{8'h13}}));
        tick(); tick(); tick();

        // saturation both ways
        ram[12'h200] = {8{8'h82, 8'h7E}};
        do_start(16'd15, 12'h200, 1'b0);
        send({8{6'h20, 6'h1F}});
        chk("lit_t3_sat", wr_data, {8{8'h80, 8'h7F}});
        tick(); tick(); tick();

        // gapped valid pattern 1,0,0,1,1
        do_start(16'd47, 12'h300, 1'b1);
        send({16{6'd1}});
        chk("lit_t4_addr0", 128'(wr_addr), 128'(12'h300));
        tick();
        chk("lit_t4_gap", 128'(wr_en), 128'(0));
        tick();
        send({16{6'h3E}});
        chk("lit_t4_addr1", 128'(wr_addr), 128'(12'h301));
        send({16{6'd7}});
        chk("lit_t4_addr2", 128'(wr_addr), 128'(12'h302));
        tick(); tick(); tick();

        // address wrap
        ram[12'hFFF] = {16{8'h01}};
        ram[12'h000] = {16{8'h02}};
        do_start(16'd31, 12'hFFF, 1'b0);
        send({16{6'h3F}});
        chk("lit_t5_addr_fff", 128'(wr_addr), 128'(12'hFFF));
        chk("lit_t5_data0", wr_data, {16{8'h00}});
        send({16{6'h3F}});
        chk("lit_t5_addr_000", 128'(wr_addr), 128'(12'h000));
        chk("lit_t5_data1", wr_data, {16{8'h01}});
        tick(); tick(); tick();

        // extra beat while flushing
        do_start(16'd15, 12'h050, 1'b1);
        send({16{6'd7}});
        send({16{6'd9}});
        chk("lit_t6_no_write", 128'(wr_en), 128'(0));
        chk("lit_t6_err", 128'(err), 128'(1));
        tick(); tick(); tick();
        chk("lit_t6_err_sticky", 128'(err), 128'(1));

        // reset after first of four chunks
        do_start(16'd63, 12'h400, 1'b1);
        chk("lit_t7_err_cleared", 128'(err), 128'(0));
        send({16{6'd1}});
        rst = 1'b1;
        #1;
        chk("lit_t7_rst_wr_en", 128'(wr_en), 128'(0));
        chk("lit_t7_rst_busy", 128'(busy), 128'(0));
        chk("lit_t7_rst_data", wr_data, 128'(0));
        valid = 1'b1; content = {16{6'd1}};
        tick();
        valid = 1'b0;
        rst = 1'b0;
        send({16{6'd1}});
        tick(); tick();

        // normal run after reset
        ram[12'h500] = {16{8'hF0}};
        ram[12'h501] = {16{8'hF0}};
        do_start(16'd31, 12'h500, 1'b0);
        send({16{6'd5}});
        chk("lit_t8_data0", wr_data, {16{8'hF5}});
        send({16{6'd5}});
        chk("lit_t8_addr1", 128'(wr_addr), 128'(12'h501));
        tick();
        chk("lit_t8_done", 128'(done), 128'(1));
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
